pupil_locator: RTL and testbench
================================

Name: pupil_locator

Overview:
- Frame-statistics block that consumes the grayscale pixel stream with its H/V raster counters.
- Classifies each valid pixel as dark or not against a runtime threshold.
- Per frame, accumulates the dark-pixel bounding box, count and coordinate sums; at frame end it divides the sums to get the pupil centroid.
- Feeds the box-marker/overlay stage with the detected pupil coordinates; it is the detect side of the mark-at-coordinates path.

Parameters:
- DATA_W, 10, pixel/grayscale width
- CNT_W, 13, H/V counter width
- ACC_W, 32, coordinate-sum accumulator width
- NUM_W, 24, dark-pixel count width
- MIN_PIXELS, 64, minimum dark count for a valid detection

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous active-low reset
- iDVAL  in  1  pixel valid
- iGRAY  in  DATA_W  grayscale pixel
- iH_Cont  in  CNT_W  horizontal position of iGRAY
- iV_Cont  in  CNT_W  vertical position of iGRAY
- iTHRESH  in  DATA_W  dark threshold, sampled every cycle
- oResultValid  out  1  one-cycle pulse: new frame result published
- oFound  out  1  last frame had count >= MIN_PIXELS
- oH_Min/oH_Max/oV_Min/oV_Max  out  CNT_W each  dark bounding box
- oH_Cen/oV_Cen  out  CNT_W each  centroid, floor(sum/count)
- oCount  out  NUM_W  dark-pixel count of last frame
- oOverrun  out  1  one-cycle pulse: frame end seen while busy
- oBusy  out  1  divider/publish in progress

Behaviour:
- Reset (iRST=0, async): every output 0; accumulators cleared; min registers set to all-ones and max registers to 0; last-V register 0; state IDLE.
- Dark pixel: iDVAL=1 and iGRAY < iTHRESH (strict). If iDVAL=0, nothing updates.
- Frame end (wrap):
  - Occurs on any iDVAL=1 cycle with iV_Cont < last-V; last-V updates on every iDVAL=1 cycle.
  - The first frame after reset has no wrap until V decreases.
  - On a wrap cycle, the current accumulators and box are copied to snapshot registers. The accumulators then restart with only the current pixel's contribution, since that pixel belongs to the new frame.
- Accumulate:
  - On each dark pixel, count increments and saturates at all-ones.
  - sumH += iH_Cont and sumV += iV_Cont, each saturating at all-ones.
  - Min/max update by compare.
- FSM states: IDLE, DIV_H, DIV_V, PUBLISH. Accumulation continues in every state.
  - IDLE, on wrap:
    - If snapshot count >= MIN_PIXELS, go to DIV_H.
    - Otherwise go to PUBLISH with found=0.
  - DIV_H: restoring divider sumH/count, 1 quotient bit per cycle, ACC_W cycles, then DIV_V.
  - DIV_V: same for sumV, then PUBLISH.
  - PUBLISH (1 cycle):
    - oResultValid=1 and oCount updates.
    - oFound=1: box and centroid outputs update; each quotient is truncated to its low CNT_W bits.
    - oFound=0: box and centroid outputs hold their previous values.
    - Then return to IDLE.
- oBusy=1 in DIV_H, DIV_V and PUBLISH.
- Latency, counted from the edge that samples the wrap pixel:
  - Found: oResultValid is high in cycle 2*ACC_W+2.
  - Not found: oResultValid is high in cycle 2.
- Wrap while not IDLE:
  - No snapshot is taken; the in-flight result still publishes.
  - oOverrun pulses 1 cycle.
  - The accumulators still restart, so the completed frame's stats are lost.
- Wrap and PUBLISH in the same cycle: treated as busy, so the overrun rule applies.
- Divide: count is nonzero whenever the divider runs (MIN_PIXELS >= 1 is required).
- Reset mid-operation: immediate return to reset state; no oResultValid for the aborted frame. The next wrap after reset behaves as for the first frame.

Test Plan:
1. Reset check: assert iRST=0 mid-stream → all outputs 0, oBusy=0; release → no oResultValid until a V wrap occurs.
2. Dark square detected:
   - Stimulus: 64x48 frame; background gray 500; 8x8 square gray 50 at H 20..27, V 10..17; iTHRESH=100; then start the next frame (V back to 0).
   - Response: oResultValid at cycle 66 (ACC_W=32); oFound=1; oCount=64; box 20/27/10/17; oH_Cen=23 (1504/64); oV_Cen=13 (864/64).
3. Below minimum: 4x4 dark square → oResultValid at cycle 2; oFound=0; oCount=16; box and centroid keep the values from scenario 2.
4. Threshold edge: iTHRESH=100; pixels of gray 100 and 99 at (5,5) and (6,5) only → oCount=1, oH_Min=oH_Max=6 (MIN_PIXELS=1 build).
5. Valid gating: dark pixels presented with iDVAL=0 → not counted and no V-wrap detection; oCount unchanged by those pixels.
6. Overrun/abort:
   - Force a second wrap 10 cycles after the first (found case) → oOverrun pulse; first result still published at cycle 66; no second oResultValid.
   - Separately, reset during DIV_V → no oResultValid; the following frame publishes correctly.

Source files
------------

// File: rtl/pupil_locator.sv
// Dark-pixel statistics per frame: bounding box, count and coordinate sums,
// then a serial divide at frame end to publish the pupil centroid.
module pupil_locator #(
  parameter int DATA_W     = 10,
  parameter int CNT_W      = 13,
  parameter int ACC_W      = 32,
  parameter int NUM_W      = 24,
  parameter int MIN_PIXELS = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iGRAY,
  input  logic [CNT_W-1:0]  iH_Cont,
  input  logic [CNT_W-1:0]  iV_Cont,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic              oResultValid,
  output logic              oFound,
  output logic [CNT_W-1:0]  oH_Min,
  output logic [CNT_W-1:0]  oH_Max,
  output logic [CNT_W-1:0]  oV_Min,
  output logic [CNT_W-1:0]  oV_Max,
  output logic [CNT_W-1:0]  oH_Cen,
  output logic [CNT_W-1:0]  oV_Cen,
  output logic [NUM_W-1:0]  oCount,
  output logic              oOverrun,
  output logic              oBusy
);
  localparam int BIT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ACC_W - 1);
  localparam logic [NUM_W-1:0] MIN_CNT  = NUM_W'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV_H, DIV_V, PUBLISH} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_last_v;
  logic [NUM_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_sum_h;
  logic [ACC_W-1:0]   r_sum_v;
  logic [CNT_W-1:0]   r_h_min;
  logic [CNT_W-1:0]   r_h_max;
  logic [CNT_W-1:0]   r_v_min;
  logic [CNT_W-1:0]   r_v_max;

  logic [NUM_W-1:0]   r_s_cnt;
  logic [ACC_W-1:0]   r_s_sum_v;
  logic [CNT_W-1:0]   r_s_h_min;
  logic [CNT_W-1:0]   r_s_h_max;
  logic [CNT_W-1:0]   r_s_v_min;
  logic [CNT_W-1:0]   r_s_v_max;
  logic               r_s_found;

  logic [ACC_W-1:0]   r_dvd;
  logic [NUM_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_quo;
  logic [BIT_W-1:0]   r_bit;
  logic [CNT_W-1:0]   r_q_h;
  logic [CNT_W-1:0]   r_q_v;

  logic               r_result_valid;
  logic               r_o_found;
  logic [CNT_W-1:0]   r_o_h_min;
  logic [CNT_W-1:0]   r_o_h_max;
  logic [CNT_W-1:0]   r_o_v_min;
  logic [CNT_W-1:0]   r_o_v_max;
  logic [CNT_W-1:0]   r_o_h_cen;
  logic [CNT_W-1:0]   r_o_v_cen;
  logic [NUM_W-1:0]   r_o_count;
  logic               r_overrun;

  logic               w_dark;
  logic               w_wrap;
  logic               w_found;
  logic [ACC_W-1:0]   w_h_ext;
  logic [ACC_W-1:0]   w_v_ext;
  logic [ACC_W:0]     w_sum_h_add;
  logic [ACC_W:0]     w_sum_v_add;
  logic [NUM_W:0]     w_trial;
  logic               w_ge;
  logic [NUM_W-1:0]   w_rem_next;
  logic [CNT_W-1:0]   w_quo_next;
  logic               w_last;

  assign w_dark      = iDVAL && (iGRAY < iTHRESH);
  assign w_wrap      = iDVAL && (iV_Cont < r_last_v);
  assign w_found     = (r_cnt >= MIN_CNT);
  assign w_h_ext     = {{(ACC_W-CNT_W){1'b0}}, iH_Cont};
  assign w_v_ext     = {{(ACC_W-CNT_W){1'b0}}, iV_Cont};
  assign w_sum_h_add = {1'b0, r_sum_h} + {1'b0, w_h_ext};
  assign w_sum_v_add = {1'b0, r_sum_v} + {1'b0, w_v_ext};

  // Restoring divide step; the remainder stays below the divisor, so the
  // subtraction fits NUM_W bits and only the low CNT_W quotient bits are kept.
  assign w_trial    = {r_rem, r_dvd[ACC_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_s_cnt});
  assign w_rem_next = w_ge ? (w_trial[NUM_W-1:0] - r_s_cnt) : w_trial[NUM_W-1:0];
  assign w_quo_next = {r_quo[CNT_W-2:0], w_ge};
  assign w_last     = (r_bit == LAST_BIT);

  // The wrap pixel opens the new frame, so it seeds the accumulators.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_last_v <= '0;
      r_cnt    <= '0;
      r_sum_h  <= '0;
      r_sum_v  <= '0;
      r_h_min  <= '1;
      r_h_max  <= '0;
      r_v_min  <= '1;
      r_v_max  <= '0;
    end else if (iDVAL) begin
      r_last_v <= iV_Cont;
      if (w_wrap) begin
        r_cnt   <= w_dark ? NUM_W'(1) : '0;
        r_sum_h <= w_dark ? w_h_ext : '0;
        r_sum_v <= w_dark ? w_v_ext : '0;
        r_h_min <= w_dark ? iH_Cont : '1;
        r_h_max <= w_dark ? iH_Cont : '0;
        r_v_min <= w_dark ? iV_Cont : '1;
        r_v_max <= w_dark ? iV_Cont : '0;
      end else if (w_dark) begin
        r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        r_sum_h <= w_sum_h_add[ACC_W] ? '1 : w_sum_h_add[ACC_W-1:0];
        r_sum_v <= w_sum_v_add[ACC_W] ? '1 : w_sum_v_add[ACC_W-1:0];
        if (iH_Cont < r_h_min) r_h_min <= iH_Cont;
        if (iH_Cont > r_h_max) r_h_max <= iH_Cont;
        if (iV_Cont < r_v_min) r_v_min <= iV_Cont;
        if (iV_Cont > r_v_max) r_v_max <= iV_Cont;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state        <= IDLE;
      r_s_cnt        <= '0;
      r_s_sum_v      <= '0;
      r_s_h_min      <= '0;
      r_s_h_max      <= '0;
      r_s_v_min      <= '0;
      r_s_v_max      <= '0;
      r_s_found      <= 1'b0;
      r_dvd          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_bit          <= '0;
      r_q_h          <= '0;
      r_q_v          <= '0;
      r_result_valid <= 1'b0;
      r_o_found      <= 1'b0;
      r_o_h_min      <= '0;
      r_o_h_max      <= '0;
      r_o_v_min      <= '0;
      r_o_v_max      <= '0;
      r_o_h_cen      <= '0;
      r_o_v_cen      <= '0;
      r_o_count      <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_overrun      <= w_wrap && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_wrap) begin
            r_s_cnt   <= r_cnt;
            r_s_sum_v <= r_sum_v;
            r_s_h_min <= r_h_min;
            r_s_h_max <= r_h_max;
            r_s_v_min <= r_v_min;
            r_s_v_max <= r_v_max;
            r_s_found <= w_found;
            r_dvd     <= r_sum_h;
            r_rem     <= '0;
            r_quo     <= '0;
            r_bit     <= '0;
            r_state   <= w_found ? DIV_H : PUBLISH;
          end
        end
        DIV_H, DIV_V: begin
          r_dvd <= {r_dvd[ACC_W-2:0], 1'b0};
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_bit <= r_bit + 1'b1;
          if (w_last) begin
            r_rem <= '0;
            r_quo <= '0;
            r_bit <= '0;
            if (r_state == DIV_H) begin
              r_q_h   <= w_quo_next;
              r_dvd   <= r_s_sum_v;
              r_state <= DIV_V;
            end else begin
              r_q_v   <= w_quo_next;
              r_state <= PUBLISH;
            end
          end
        end
        PUBLISH: begin
          r_result_valid <= 1'b1;
          r_o_count      <= r_s_cnt;
          r_o_found      <= r_s_found;
          if (r_s_found) begin
            r_o_h_min <= r_s_h_min;
            r_o_h_max <= r_s_h_max;
            r_o_v_min <= r_s_v_min;
            r_o_v_max <= r_s_v_max;
            r_o_h_cen <= r_q_h;
            r_o_v_cen <= r_q_v;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oResultValid = r_result_valid;
  assign oFound       = r_o_found;
  assign oH_Min       = r_o_h_min;
  assign oH_Max       = r_o_h_max;
  assign oV_Min       = r_o_v_min;
  assign oV_Max       = r_o_v_max;
  assign oH_Cen       = r_o_h_cen;
  assign oV_Cen       = r_o_v_cen;
  assign oCount       = r_o_count;
  assign oOverrun     = r_overrun;
  assign oBusy        = (r_state != IDLE);

endmodule

// File: tb/tb_pupil_locator.sv
// Randomized frame stimulus for pupil_locator, checked against a pixel-level
// frame-statistics model with cycle-exact publish timing.
module tb_pupil_locator;
  localparam int DW = 10, CW = 13, AW = 32, NW = 24, MINP = 64;

  typedef struct packed {
    logic          found;
    logic [NW-1:0] count;
    logic [CW-1:0] hmin, hmax, vmin, vmax, hcen, vcen;
  } res_t;

  logic          iCLK = 1'b0, iRST = 1'b0, iDVAL = 1'b0;
  logic [DW-1:0] iGRAY = '0, iTHRESH = '0;
  logic [CW-1:0] iH_Cont = '0, iV_Cont = '0;
  logic          oResultValid, oFound, oOverrun, oBusy;
  logic [CW-1:0] oH_Min, oH_Max, oV_Min, oV_Max, oH_Cen, oV_Cen;
  logic [NW-1:0] oCount;

  pupil_locator #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW), .NUM_W(NW), .MIN_PIXELS(MINP)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iGRAY(iGRAY), .iH_Cont(iH_Cont),
    .iV_Cont(iV_Cont), .iTHRESH(iTHRESH), .oResultValid(oResultValid), .oFound(oFound),
    .oH_Min(oH_Min), .oH_Max(oH_Max), .oV_Min(oV_Min), .oV_Max(oV_Max),
    .oH_Cen(oH_Cen), .oV_Cen(oV_Cen), .oCount(oCount), .oOverrun(oOverrun), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  res_t obs_q[$], exp_q[$];
  int   obs_cyc_q[$], exp_cyc_q[$];
  int   obs_ovr = 0, exp_ovr = 0;
  int   n_cmp = 0, n_bad = 0;
  res_t mon_r;

  always @(negedge iCLK) begin
    if (oResultValid) begin
      mon_r = {oFound, oCount, oH_Min, oH_Max, oV_Min, oV_Max, oH_Cen, oV_Cen};
      obs_q.push_back(mon_r);
      obs_cyc_q.push_back(cyc);
    end
    if (oOverrun) obs_ovr <= obs_ovr + 1;
  end

  // Frame model: what the spec says a frame's statistics are.
  longint m_cnt, m_sh, m_sv;
  int     m_hmin, m_hmax, m_vmin, m_vmax, m_last_v, m_busy_last, last_wrap_cyc;
  res_t   m_pub;
  logic [DW-1:0] fr [0:47][0:63];

  function automatic void model_frame_clear();
    m_cnt = 0; m_sh = 0; m_sv = 0;
    m_hmin = (1 << CW) - 1; m_hmax = 0; m_vmin = (1 << CW) - 1; m_vmax = 0;
  endfunction

  function automatic void model_reset();
    model_frame_clear();
    m_last_v = 0; m_busy_last = -1; m_pub = '0;
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
  endfunction

  function automatic void model_pixel(input int g, input int h, input int v, input int th);
    res_t e;
    bit   f;
    if (v < m_last_v) begin
      last_wrap_cyc = cyc;
      if (cyc <= m_busy_last) exp_ovr++;
      else begin
        f = (m_cnt >= MINP);
        e = m_pub;
        e.found = f;
        e.count = NW'(m_cnt);
        if (f) begin
          e.hmin = CW'(m_hmin); e.hmax = CW'(m_hmax);
          e.vmin = CW'(m_vmin); e.vmax = CW'(m_vmax);
          e.hcen = CW'(m_sh / m_cnt); e.vcen = CW'(m_sv / m_cnt);
        end
        m_pub = e;
        m_busy_last = cyc + (f ? 2*AW + 1 : 1);
        exp_q.push_back(e);
        exp_cyc_q.push_back(m_busy_last);
      end
      model_frame_clear();
    end
    m_last_v = v;
    if (g < th) begin
      m_cnt++; m_sh += h; m_sv += v;
      if (h < m_hmin) m_hmin = h;
      if (h > m_hmax) m_hmax = h;
      if (v < m_vmin) m_vmin = v;
      if (v > m_vmax) m_vmax = v;
    end
  endfunction

  task automatic drive(input logic dv, input int g, input int h, input int v, input int th);
    iDVAL = dv; iGRAY = DW'(g); iH_Cont = CW'(h); iV_Cont = CW'(v); iTHRESH = DW'(th);
    @(posedge iCLK); #1;
    if (dv) model_pixel(g, h, v, th);
  endtask

  // Invalid gap cycles carry dark pixels at V=0 that must be ignored.
  task automatic stream_frame(input int fw, input int fh, input int th, input int gap_pct);
    for (int v = 0; v < fh; v++)
      for (int h = 0; h < fw; h++) begin
        while ($urandom_range(99) < gap_pct) drive(1'b0, 0, $urandom_range(63), 0, th);
        drive(1'b1, fr[v][h], h, v, th);
      end
  endtask

  task automatic fill(input int fw, input int fh, input int g);
    for (int v = 0; v < fh; v++)
      for (int h = 0; h < fw; h++) fr[v][h] = DW'(g);
  endtask

  task automatic rect(input int h0, input int h1, input int v0, input int v1, input int g);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) fr[v][h] = DW'(g);
  endtask

  task automatic rand_frame(input int fw, input int fh, input int th, input int bmin, input int bmax);
    int bw, bh, h0, v0;
    for (int v = 0; v < fh; v++)
      for (int h = 0; h < fw; h++) fr[v][h] = DW'($urandom_range(1023, th));
    bw = $urandom_range(bmax, bmin); bh = $urandom_range(bmax, bmin);
    h0 = $urandom_range(fw - bw); v0 = $urandom_range(fh - bh);
    for (int v = v0; v < v0 + bh; v++)
      for (int h = h0; h < h0 + bw; h++) fr[v][h] = DW'($urandom_range(th - 1, 0));
    fr[$urandom_range(fh - 1)][$urandom_range(fw - 1)] = DW'(th);
    fr[$urandom_range(fh - 1)][$urandom_range(fw - 1)] = DW'(th - 1);
  endtask

  task automatic wait_results();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 400) begin
      drive(1'b0, 0, 0, 0, 100);
      n++;
    end
    repeat (4) drive(1'b0, 0, 0, 0, 100);
  endtask

  task automatic test_reset();
    res_t o, e;
    int   oc, ec;
    n_cmp++;
    if ({oResultValid, oFound, oH_Min, oH_Max, oV_Min, oV_Max, oH_Cen, oV_Cen, oCount, oOverrun, oBusy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b found=%b count=%0d busy=%b hmin=%0d required all zero",
               oResultValid, oFound, oCount, oBusy, oH_Min);
    end
    @(posedge iCLK); #1;
    iRST = 1'b1;
    model_reset();
    rand_frame(32, 24, 200, 9, 12);
    stream_frame(32, 24, 200, 10);
    wait_results();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_no_wrap got %0d results required 0", obs_q.size());
    end
    drive(1'b1, 1023, 0, 0, 200);
    wait_results();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_ovr != exp_ovr) begin
      n_bad++;
      $display("FAIL reset_first_frame results=%0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); oc = obs_cyc_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (o !== e || oc != ec) begin
        n_bad++;
        $display("FAIL reset_first_result got %h @%0d required %h @%0d", o, oc, e, ec);
      end
    end
  endtask

  task automatic test_dark_square();
    res_t o, e, lit;
    int   oc, ec;
    fill(64, 48, 500);
    rect(20, 27, 10, 17, 50);
    stream_frame(64, 48, 100, 0);
    drive(1'b1, 500, 0, 0, 100);
    n_cmp++;
    if (oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL square_busy got %b required 1", oBusy);
    end
    wait_results();
    lit.found = 1'b1; lit.count = 64; lit.hmin = 20; lit.hmax = 27; lit.vmin = 10; lit.vmax = 17;
    lit.hcen = 23; lit.vcen = 13;
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== lit || obs_cyc_q[0] - last_wrap_cyc + 1 != 66) begin
      n_bad++;
      $display("FAIL square_literal got n=%0d res=%h latency=%0d required n=1 res=%h latency=66",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : res_t'('0),
               (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - last_wrap_cyc + 1 : -1, lit);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); oc = obs_cyc_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (o !== e || oc != ec) begin
        n_bad++;
        $display("FAIL square_model got %h @%0d required %h @%0d", o, oc, e, ec);
      end
    end
  endtask

  // 4x4 blob plus a gray==thresh pixel (not dark) and gray==thresh-1 (dark).
  task automatic test_below_min();
    res_t lit;
    fill(64, 48, 500);
    rect(40, 43, 30, 33, 50);
    fr[5][5] = 10'd100;
    fr[5][6] = 10'd99;
    stream_frame(64, 48, 100, 5);
    drive(1'b1, 500, 0, 0, 100);
    wait_results();
    lit.found = 1'b0; lit.count = 17; lit.hmin = 20; lit.hmax = 27; lit.vmin = 10; lit.vmax = 17;
    lit.hcen = 23; lit.vcen = 13;
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== lit || exp_q[0] !== lit ||
        obs_cyc_q[0] - last_wrap_cyc + 1 != 2) begin
      n_bad++;
      $display("FAIL below_min got n=%0d res=%h latency=%0d required n=1 res=%h latency=2",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : res_t'('0),
               (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - last_wrap_cyc + 1 : -1, lit);
    end
    model_reset_queues();
  endtask

  function automatic void model_reset_queues();
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
  endfunction

  task automatic test_random_frames(input int gap_pct);
    res_t o, e;
    int   oc, ec, th;
    for (int f = 0; f < 5; f++) begin
      th = $urandom_range(300, 60);
      if (f == 2) rand_frame(32, 24, th, 3, 6);
      else        rand_frame(32, 24, th, 8, 14);
      stream_frame(32, 24, th, gap_pct);
    end
    drive(1'b1, 1023, 0, 0, 100);
    wait_results();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_ovr != exp_ovr) begin
      n_bad++;
      $display("FAIL random_count gap=%0d results=%0d overruns=%0d required %0d/%0d",
               gap_pct, obs_q.size(), obs_ovr, exp_q.size(), exp_ovr);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); oc = obs_cyc_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (o !== e || oc != ec) begin
        n_bad++;
        $display("FAIL random_result gap=%0d got %h @%0d required %h @%0d", gap_pct, o, oc, e, ec);
      end
    end
    model_reset_queues();
  endtask

  task automatic test_overrun();
    res_t o, e;
    int   oc, ec, ovr0;
    ovr0 = obs_ovr;
    fill(64, 48, 500);
    rect(30, 39, 20, 29, 20);
    stream_frame(64, 48, 100, 0);
    drive(1'b1, 500, 0, 0, 100);
    for (int h = 0; h < 9; h++) drive(1'b1, 500, h, 1, 100);
    drive(1'b1, 10, 0, 0, 100);
    wait_results();
    n_cmp++;
    if (obs_ovr - ovr0 != 1 || obs_ovr != exp_ovr || obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL overrun_count pulses=%0d results=%0d required pulses=1 results=1",
               obs_ovr - ovr0, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); oc = obs_cyc_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (o !== e || oc != ec) begin
        n_bad++;
        $display("FAIL overrun_result got %h @%0d required %h @%0d", o, oc, e, ec);
      end
    end
    model_reset_queues();
  endtask

  task automatic test_reset_abort();
    res_t o, e;
    int   oc, ec;
    rand_frame(32, 24, 150, 9, 12);
    stream_frame(32, 24, 150, 0);
    drive(1'b1, 1023, 0, 0, 150);
    repeat (40) drive(1'b0, 0, 0, 0, 150);
    iRST = 1'b0;
    #1;
    n_cmp++;
    if ({oResultValid, oFound, oH_Min, oH_Max, oV_Min, oV_Max, oH_Cen, oV_Cen, oCount, oOverrun, oBusy} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs got valid=%b found=%b count=%0d busy=%b required all zero",
               oResultValid, oFound, oCount, oBusy);
    end
    repeat (3) drive(1'b0, 0, 0, 0, 150);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_no_result got %0d results required 0", obs_q.size());
    end
    model_reset();
    iRST = 1'b1;
    rand_frame(32, 24, 150, 9, 12);
    stream_frame(32, 24, 150, 0);
    rand_frame(32, 24, 150, 9, 12);
    stream_frame(32, 24, 150, 0);
    wait_results();
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL abort_recover results=%0d required 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); oc = obs_cyc_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (o !== e || oc != ec) begin
        n_bad++;
        $display("FAIL abort_recover_result got %h @%0d required %h @%0d", o, oc, e, ec);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge iCLK);
    #1;
    test_reset();
    test_dark_square();
    test_below_min();
    test_random_frames(0);
    test_random_frames(40);
    test_overrun();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
